// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared widths for the serial-to-parallel deserializer
package sipo_pkg;

  localparam int BYTE_W = 8;

endpackage : sipo_pkg

// File: rtl/sipo.sv
// rtl/sipo.sv - valid-qualified serial-in/parallel-out deserializer
module sipo
  import sipo_pkg::*;
#(
  parameter int DATA_WIDTH = BYTE_W,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_serial_i,
  input  logic                  valid_serial_i,
  output logic [DATA_WIDTH-1:0] data_parallel_o,
  output logic                  byte_ready_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_ready;

  logic [DATA_WIDTH-1:0] w_shift_next;
  logic                  w_last;

  // The completing bit is folded into the word on its own edge, so the
  // parallel register loads from the next-shift value, not the old one.
  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign w_shift_next = {data_serial_i, r_shift[DATA_WIDTH-1:1]};
    end else begin : g_msb_first
      assign w_shift_next = {r_shift[DATA_WIDTH-2:0], data_serial_i};
    end
  endgenerate

  assign w_last = valid_serial_i && (r_cnt == CNT_W'(DATA_WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= w_last;
      if (valid_serial_i) begin
        r_shift <= w_shift_next;
        r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
      end
      if (w_last) begin
        r_data <= w_shift_next;
      end
    end
  end

  assign data_parallel_o = r_data;
  assign byte_ready_o    = r_ready;

endmodule : sipo

// File: tb/tb_sipo.sv
// tb/tb_sipo.sv - directed self-checking bench for sipo (both bit orders)
module tb_sipo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       data_serial;
  logic       valid_serial;
  logic [7:0] data_lsb;
  logic       ready_lsb;
  logic [7:0] data_msb;
  logic       ready_msb;

  int         n_asrt = 0;
  int         n_fail = 0;
  logic [7:0] exp_word;
  logic [7:0] exp_rev;
  logic [7:0] bytes_v;

  always #5 clk = ~clk;

  sipo #(.DATA_WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk             (clk),
    .rst_n           (rst_n),
    .data_serial_i   (data_serial),
    .valid_serial_i  (valid_serial),
    .data_parallel_o (data_lsb),
    .byte_ready_o    (ready_lsb)
  );

  sipo #(.DATA_WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
    .clk             (clk),
    .rst_n           (rst_n),
    .data_serial_i   (data_serial),
    .valid_serial_i  (valid_serial),
    .data_parallel_o (data_msb),
    .byte_ready_o    (ready_msb)
  );

  function automatic logic [7:0] bitrev(input logic [7:0] v);
    for (int i = 0; i < 8; i++) bitrev[i] = v[7-i];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; outputs checked 1 time unit after the edge.
  task automatic step(input logic v, input logic b, input logic rdy);
    valid_serial = v;
    data_serial  = b;
    @(posedge clk);
    #1;
    chk("ready_lsb", {7'b0, ready_lsb}, {7'b0, rdy});
    chk("ready_msb", {7'b0, ready_msb}, {7'b0, rdy});
    chk("data_lsb", data_lsb, exp_word);
    chk("data_msb", data_msb, exp_rev);
  endtask

  task automatic send_byte(input logic [7:0] w, input int max_gap);
    for (int k = 0; k < 8; k++) begin
      if (max_gap > 0) begin
        int g;
        g = $urandom_range(0, max_gap);
        for (int j = 0; j < g; j++) step(1'b0, 1'b1, 1'b0);
      end
      if (k == 7) begin
        exp_word = w;
        exp_rev  = bitrev(w);
      end
      step(1'b1, w[k], k == 7);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    valid_serial = 1'b0;
    data_serial  = 1'b0;
    exp_word     = 8'h00;
    exp_rev      = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // 0xA5 contiguous, then idle: output must hold.
    send_byte(8'hA5, 0);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Back-to-back words with valid held high.
    send_byte(8'hFF, 0);
    send_byte(8'h00, 0);
    step(1'b0, 1'b1, 1'b0);

    // Random bytes with inter- and intra-byte gaps.
    for (int n = 0; n < 5; n++) begin
      bytes_v = 8'($urandom_range(0, 255));
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      send_byte(bytes_v, 2);
    end
    send_byte(8'h3B, 0);
    send_byte(8'hC8, 1);

    // Partial 0x3C then asynchronous reset mid-word.
    bytes_v = 8'h3C;
    for (int k = 0; k < 4; k++) step(1'b1, bytes_v[k], 1'b0);
    valid_serial = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_word = 8'h00;
    exp_rev  = 8'h00;
    chk("async_rst_lsb", data_lsb, 8'h00);
    chk("async_rst_msb", data_msb, 8'h00);
    chk("async_rst_rdy", {7'b0, ready_lsb}, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    send_byte(8'h5A, 1);
    send_byte(8'h81, 0);
    step(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule : tb_sipo
